universal_shift_reg: RTL and testbench
======================================

Name: universal_shift_reg

Overview:
- Parametrised successor to the team's 4-bit load/shift-right register.
- Generalised to N bits with W-bit serial lanes and seven operating modes: hold, load, logical shift left/right, rotate left/right, arithmetic shift right, plus clear.
- A counted burst engine (start/busy/done) performs a programmed number of shift steps autonomously.
- Sits in datapaths as a serialiser/deserialiser, barrel-free multi-step shifter and bit-stream aligner.

Parameters:
- N, 8, register width in bits.
- W, 1, bits moved per shift step; N must be a multiple of W, with W < N.
- CW, $clog2(N+1), width of the burst step count.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  clock enable; low freezes q, state and step counter.
- mode  in  3  operation select, encoded as below.
- d  in  N  parallel load data.
- si_r  in  W  serial-in for right shift; enters at q[N-1:N-W].
- si_l  in  W  serial-in for left shift; enters at q[W-1:0].
- start  in  1  burst request.
- cnt  in  CW  burst step count.
- q  out  N  register contents.
- so_r  out  W  equals q[W-1:0].
- so_l  out  W  equals q[N-1:N-W].
- busy  out  1  burst in progress.
- done  out  1  one-cycle burst-complete pulse.

Behaviour:
- Reset: rst_n low asynchronously forces q=0, busy=0, done=0, state IDLE and step counter 0. This holds regardless of en, including mid-burst. A burst interrupted by reset is abandoned with no done pulse.
- Mode encoding (one step):
  - 000 hold.
  - 001 load q<=d.
  - 010 SRL q<={si_r, q[N-1:W]}.
  - 011 SLL q<={q[N-W-1:0], si_l}.
  - 100 ROR q<={q[W-1:0], q[N-1:W]}.
  - 101 ROL q<={q[N-W-1:0], q[N-1:N-W]}.
  - 110 SRA q<={{W{q[N-1]}}, q[N-1:W]}.
  - 111 clear q<=0.
- so_r and so_l are combinational from q. They show the bits about to leave before the step executes.
- States: IDLE, BURST.
- IDLE, en=1, start=0: the mode step is applied at the clock edge.
- IDLE, en=1, start=1, mode in 010..110:
  - If cnt!=0: latch mode and cnt, go to BURST, busy=1 from the next cycle. q is NOT updated on the start cycle.
  - If cnt==0: stay IDLE, q unchanged, done=1 for the next cycle.
- IDLE, start=1 with mode in 000, 001 or 111: start is ignored and the direct mode step applies.
- IDLE, en=0: nothing happens. start is ignored and is not remembered.
- BURST, each cycle with en=1:
  - Apply the latched op and decrement the remaining count.
  - On the step where remaining goes 1->0, go to IDLE. busy drops and done=1 in the following cycle.
- BURST with en=0: stall; q and the count are held and busy stays 1.
- BURST ignores the mode, start, d and cnt inputs. A start during BURST is dropped.
- done: registered, exactly one cycle high, coincident with the first IDLE cycle. It is not gated by en.
- Burst latency: cnt en-high cycles after the start cycle. busy is high for cnt+stall cycles.
- cnt may exceed N/W. Rotates wrap and shifts saturate to the fill pattern.
- Serial inputs are sampled live on every burst step. They are not latched at start.

Test Plan:
- Reset: assert rst_n=0 mid-operation with N=8, W=1 -> q=0x00, busy=0, done=0 immediately and without a clock edge.
- Direct ops (N=8, W=1):
  - load 0xA5 -> so_r=1.
  - SRL with si_r=1 -> q=0xD2.
  - SLL with si_l=0 -> q=0xA4.
  - clear -> q=0x00.
- Burst SRA: q=0x80, start with mode=110, cnt=3 -> busy for exactly 3 cycles, q=0xF0, done one-cycle pulse right after, then busy=0.
- Burst ROL with a stall: q=0x12, mode=101, cnt=4, en low for 2 cycles mid-burst -> q=0x21, busy for 6 cycles, done one cycle later.
- Edge cases:
  - cnt=0 start -> q unchanged, busy never rises, done pulses once.
  - start during BURST -> ignored, original burst completes.
  - rst_n low mid-burst -> no done pulse.
- Wide lane (N=8, W=2): q=0x01, SLL with si_l=2'b11 -> 0x07. Then ROR -> 0xC1; so_r before the ROR = 2'b11.

Source files
------------

// File: rtl/universal_shift_reg.sv
// N-bit universal shift register with W-bit serial lanes, seven step modes
// and a counted burst engine that repeats a shift/rotate step autonomously.
module universal_shift_reg #(
   parameter int N  = 8,
   parameter int W  = 1,
   parameter int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [2:0]    mode,
   input  logic [N-1:0]  d,
   input  logic [W-1:0]  si_r,
   input  logic [W-1:0]  si_l,
   input  logic          start,
   input  logic [CW-1:0] cnt,
   output logic [N-1:0]  q,
   output logic [W-1:0]  so_r,
   output logic [W-1:0]  so_l,
   output logic          busy,
   output logic          done
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   localparam logic [2:0]    MODE_HOLD  = 3'b000;
   localparam logic [2:0]    MODE_LOAD  = 3'b001;
   localparam logic [2:0]    MODE_SRL   = 3'b010;
   localparam logic [2:0]    MODE_SLL   = 3'b011;
   localparam logic [2:0]    MODE_ROR   = 3'b100;
   localparam logic [2:0]    MODE_ROL   = 3'b101;
   localparam logic [2:0]    MODE_SRA   = 3'b110;
   localparam logic [2:0]    MODE_CLR   = 3'b111;
   localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};

   state_t        state_q, state_d;
   logic [N-1:0]  q_q, q_d;
   logic [CW-1:0] rem_q, rem_d;
   logic [2:0]    op_q, op_d;
   logic          done_q, done_d;
   logic          is_burst_op;

   function automatic logic [N-1:0] step_fn(
      input logic [2:0]   op,
      input logic [N-1:0] cur,
      input logic [N-1:0] ld,
      input logic [W-1:0] sr,
      input logic [W-1:0] sl
   );
      case (op)
         MODE_HOLD: step_fn = cur;
         MODE_LOAD: step_fn = ld;
         MODE_SRL:  step_fn = {sr, cur[N-1:W]};
         MODE_SLL:  step_fn = {cur[N-W-1:0], sl};
         MODE_ROR:  step_fn = {cur[W-1:0], cur[N-1:W]};
         MODE_ROL:  step_fn = {cur[N-W-1:0], cur[N-1:N-W]};
         MODE_SRA:  step_fn = {{W{cur[N-1]}}, cur[N-1:W]};
         MODE_CLR:  step_fn = {N{1'b0}};
         default:   step_fn = cur;
      endcase
   endfunction

   assign is_burst_op = (mode >= MODE_SRL) && (mode <= MODE_SRA);

   // Next-state: direct steps in IDLE, latched op repeated while BURST has steps left
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      rem_d   = rem_q;
      op_d    = op_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               if (start && is_burst_op) begin
                  if (cnt != CNT_ZERO) begin
                     state_d = ST_BURST;
                     rem_d   = cnt;
                     op_d    = mode;
                  end else begin
                     done_d = 1'b1;
                  end
               end else begin
                  q_d = step_fn(mode, q_q, d, si_r, si_l);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (en) begin
               q_d   = step_fn(op_q, q_q, d, si_r, si_l);
               rem_d = rem_q - CNT_ONE;
               if (rem_q == CNT_ONE) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_BURST;
               end
            end else begin
               state_d = ST_BURST;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // done is written every cycle so the pulse lasts one cycle even with en low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         q_q     <= {N{1'b0}};
         rem_q   <= CNT_ZERO;
         op_q    <= MODE_HOLD;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
         done_q  <= done_d;
      end
   end

   assign q    = q_q;
   assign so_r = q_q[W-1:0];
   assign so_l = q_q[N-1:N-W];
   assign busy = (state_q == ST_BURST);
   assign done = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench: two instances (W=1 and W=2, N=8) driven by shared stimulus,
// compared every cycle against an arithmetic reference model plus directed checks.
module tb_universal_shift_reg;

   logic       clk = 1'b0;
   logic       rst_n, en, start;
   logic [2:0] mode;
   logic [7:0] d;
   logic [1:0] sir, sil;
   logic [3:0] cnt;

   logic [7:0] qa, qb;
   logic       sora, sola, busya, donea, busyb, doneb;
   logic [1:0] sorb, solb;

   int errors = 0;
   int checks = 0;
   int bc;

   typedef struct packed {
      logic [7:0] q;
      logic       busy;
      logic       done;
      logic [2:0] op;
      logic [3:0] rem;
   } mdl_t;

   mdl_t ma, mb;

   universal_shift_reg #(.N(8), .W(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
      .si_r(sir[0:0]), .si_l(sil[0:0]), .start(start), .cnt(cnt),
      .q(qa), .so_r(sora), .so_l(sola), .busy(busya), .done(donea)
   );

   universal_shift_reg #(.N(8), .W(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
      .si_r(sir), .si_l(sil), .start(start), .cnt(cnt),
      .q(qb), .so_r(sorb), .so_l(solb), .busy(busyb), .done(doneb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // one step computed with plain integer shifts on an 8-bit value
   function automatic logic [7:0] op_apply(input logic [2:0] op, input logic [7:0] cur,
                                           input logic [7:0] ld, input logic [1:0] sr,
                                           input logic [1:0] sl, input int w);
      int c;
      int lm;
      int r;
      logic signed [7:0] s;
      c  = int'(cur);
      lm = (1 << w) - 1;
      s  = cur;
      case (op)
         3'd0:    r = c;
         3'd1:    r = int'(ld);
         3'd2:    r = (c >> w) | ((int'(sr) & lm) << (8 - w));
         3'd3:    r = (c << w) | (int'(sl) & lm);
         3'd4:    r = (c >> w) | (c << (8 - w));
         3'd5:    r = (c << w) | (c >> (8 - w));
         3'd6:    r = int'(8'(s >>> w));
         default: r = 0;
      endcase
      return r[7:0];
   endfunction

   function automatic mdl_t mdl_next(input mdl_t m, input int w);
      mdl_t r;
      r      = m;
      r.done = 1'b0;
      if (en) begin
         if (!m.busy) begin
            if (start && mode >= 3'd2 && mode <= 3'd6) begin
               if (cnt == 4'd0) begin
                  r.done = 1'b1;
               end else begin
                  r.busy = 1'b1;
                  r.rem  = cnt;
                  r.op   = mode;
               end
            end else begin
               r.q = op_apply(mode, m.q, d, sir, sil, w);
            end
         end else begin
            r.q   = op_apply(m.op, m.q, d, sir, sil, w);
            r.rem = m.rem - 4'd1;
            if (r.rem == 4'd0) begin
               r.busy = 1'b0;
               r.done = 1'b1;
            end
         end
      end
      return r;
   endfunction

   task automatic compare_all();
      chk("qa", 32'(qa), 32'(ma.q));
      chk("busya", 32'(busya), 32'(ma.busy));
      chk("donea", 32'(donea), 32'(ma.done));
      chk("so_ra", 32'(sora), 32'(ma.q & 8'h01));
      chk("so_la", 32'(sola), 32'(ma.q >> 7));
      chk("qb", 32'(qb), 32'(mb.q));
      chk("busyb", 32'(busyb), 32'(mb.busy));
      chk("doneb", 32'(doneb), 32'(mb.done));
      chk("so_rb", 32'(sorb), 32'(mb.q & 8'h03));
      chk("so_lb", 32'(solb), 32'(mb.q >> 6));
   endtask

   task automatic run_cycle();
      @(posedge clk);
      ma = mdl_next(ma, 1);
      mb = mdl_next(mb, 2);
      @(negedge clk);
      compare_all();
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      ma = '0;
      mb = '0;
      compare_all();
      chk("rst_q", 32'(qa), 32'h00);
      chk("rst_busy", 32'(busya), 32'h0);
      chk("rst_done", 32'(donea), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_in(input logic [2:0] m, input logic [7:0] dv, input logic st, input logic [3:0] c);
      mode  = m;
      d     = dv;
      start = st;
      cnt   = c;
   endtask

   initial begin
      rst_n = 1'b1; en = 1'b1; start = 1'b0; mode = 3'd0; d = 8'h00;
      sir = 2'b00; sil = 2'b00; cnt = 4'd0;
      ma = '0; mb = '0;
      async_reset();

      // direct ops
      set_in(3'd1, 8'hA5, 1'b0, 4'd0); run_cycle();
      chk("load_q", 32'(qa), 32'hA5);
      chk("load_so_r", 32'(sora), 32'h1);
      sir = 2'b01; set_in(3'd2, 8'h00, 1'b0, 4'd0); run_cycle();
      chk("srl_q", 32'(qa), 32'hD2);
      sil = 2'b00; set_in(3'd3, 8'h00, 1'b0, 4'd0); run_cycle();
      chk("sll_q", 32'(qa), 32'hA4);
      set_in(3'd7, 8'h00, 1'b0, 4'd0); run_cycle();
      chk("clr_q", 32'(qa), 32'h00);

      // burst SRA cnt=3; inputs changed during the burst must be ignored
      set_in(3'd1, 8'h80, 1'b0, 4'd0); run_cycle();
      set_in(3'd6, 8'h00, 1'b1, 4'd3); run_cycle();
      chk("sra_start_q", 32'(qa), 32'h80);
      set_in(3'd1, 8'hFF, 1'b0, 4'd0);
      bc = int'(busya);
      for (int i = 0; i < 10; i++) begin
         run_cycle();
         if (!busya) break;
         bc++;
      end
      mode = 3'd0;
      chk("sra_busy_len", 32'(bc), 32'd3);
      chk("sra_q", 32'(qa), 32'hF0);
      chk("sra_done", 32'(donea), 32'h1);
      run_cycle();
      chk("sra_done_drop", 32'(donea), 32'h0);
      chk("sra_busy_after", 32'(busya), 32'h0);

      // burst ROL cnt=4 with a 2-cycle stall
      set_in(3'd1, 8'h12, 1'b0, 4'd0); run_cycle();
      set_in(3'd5, 8'h00, 1'b1, 4'd4); run_cycle();
      set_in(3'd0, 8'h00, 1'b0, 4'd0);
      bc = int'(busya);
      for (int i = 0; i < 6; i++) begin
         en = !(i == 2 || i == 3);
         run_cycle();
         bc += int'(busya);
      end
      en = 1'b1;
      chk("rol_busy_len", 32'(bc), 32'd6);
      chk("rol_q", 32'(qa), 32'h21);
      chk("rol_done", 32'(donea), 32'h1);
      run_cycle();
      chk("rol_done_drop", 32'(donea), 32'h0);

      // cnt=0 start
      set_in(3'd1, 8'h5A, 1'b0, 4'd0); run_cycle();
      set_in(3'd2, 8'h00, 1'b1, 4'd0); run_cycle();
      chk("cnt0_q", 32'(qa), 32'h5A);
      chk("cnt0_busy", 32'(busya), 32'h0);
      chk("cnt0_done", 32'(donea), 32'h1);
      set_in(3'd0, 8'h00, 1'b0, 4'd0); run_cycle();
      chk("cnt0_done_drop", 32'(donea), 32'h0);
      chk("cnt0_busy2", 32'(busya), 32'h0);

      // start during burst is dropped
      sir = 2'b00;
      set_in(3'd1, 8'h3C, 1'b0, 4'd0); run_cycle();
      set_in(3'd2, 8'h00, 1'b1, 4'd2); run_cycle();
      set_in(3'd5, 8'h00, 1'b1, 4'd5); run_cycle(); run_cycle();
      chk("drop_q", 32'(qa), 32'h0F);
      chk("drop_busy", 32'(busya), 32'h0);
      chk("drop_done", 32'(donea), 32'h1);
      set_in(3'd0, 8'h00, 1'b0, 4'd0); run_cycle();

      // reset mid-burst: no done afterwards
      set_in(3'd4, 8'h00, 1'b1, 4'd5); run_cycle();
      set_in(3'd0, 8'h00, 1'b0, 4'd0); run_cycle(); run_cycle();
      async_reset();
      for (int i = 0; i < 6; i++) begin
         run_cycle();
         chk("rst_no_done", 32'(donea), 32'h0);
      end

      // wide lane W=2
      set_in(3'd1, 8'h01, 1'b0, 4'd0); run_cycle();
      sil = 2'b11; set_in(3'd3, 8'h00, 1'b0, 4'd0); run_cycle();
      chk("w2_sll_q", 32'(qb), 32'h07);
      chk("w2_so_r", 32'(sorb), 32'h3);
      set_in(3'd4, 8'h00, 1'b0, 4'd0); run_cycle();
      chk("w2_ror_q", 32'(qb), 32'hC1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         en    = ($urandom_range(0, 9) != 0);
         mode  = 3'($urandom_range(0, 7));
         start = ($urandom_range(0, 4) == 0);
         cnt   = 4'($urandom_range(0, 10));
         d     = 8'($urandom);
         sir   = 2'($urandom);
         sil   = 2'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            async_reset();
         end else begin
            run_cycle();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
